pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 16-bit, 5-stage pipeline. It drives the write enables of the PC, IF_ID and ID_EX registers, and the ID_EX enable is the `hit` input of ID_EX. It detects load-use hazards, squashes wrong-path instructions on a taken branch, and freezes the pipeline while an instruction-cache or data-cache line fill is in progress. A fill watchdog catches a hung memory, and a saturating counter records stall cycles for performance measurement.

---
 rtl/pipeline_hazard_ctrl.sv | 152 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl : stall/flush sequencer with cache-fill freeze and watchdog
// Revision: 1.0
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int FILL_TIMEOUT = 255,
  parameter int WAIT_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        icache_hit,
  input  logic        dmem_req,
  input  logic        dcache_hit,
  input  logic        fill_done,
  input  logic [2:0]  id_rs,
  input  logic [2:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        ex_mem_read,
  input  logic [2:0]  ex_rt,
  input  logic        ex_branch_taken,
  output logic        pc_we,
  output logic        if_id_we,
  output logic        if_id_flush,
  output logic        id_ex_en,
  output logic        id_ex_bubble,
  output logic        fill_req,
  output logic        fill_sel,
  output logic        fault,
  output logic [1:0]  state,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_IFILL = 2'd1,
    ST_DFILL = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(FILL_TIMEOUT);

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                fill_req_q, fill_req_d;
  logic                fill_sel_q, fill_sel_d;
  logic                fault_q, fault_d;
  logic [15:0]         stall_count_q, stall_count_d;

  logic dmiss, imiss, lu;

  assign dmiss = dmem_req & ~dcache_hit;
  assign imiss = ~icache_hit;
  assign lu    = ex_mem_read & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    fill_req_d   = fill_req_q;
    fill_sel_d   = fill_sel_q;
    fault_d      = fault_q;
    pc_we        = 1'b0;
    if_id_we     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b0;
    id_ex_bubble = 1'b0;

    case (state_q)
      ST_RUN: begin
        wait_d = '0;
        if (dmiss) begin
          state_d    = ST_DFILL;
          fill_req_d = 1'b1;
          fill_sel_d = 1'b1;
        end else if (imiss) begin
          state_d    = ST_IFILL;
          fill_req_d = 1'b1;
          fill_sel_d = 1'b0;
        end else if (ex_branch_taken) begin
          pc_we        = 1'b1;
          if_id_we     = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_en     = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (lu) begin
          id_ex_en     = 1'b1;
          id_ex_bubble = 1'b1;
        end else begin
          pc_we    = 1'b1;
          if_id_we = 1'b1;
          id_ex_en = 1'b1;
        end
      end
      ST_IFILL, ST_DFILL: begin
        // fill_done takes precedence over a watchdog expiry in the same cycle
        if (fill_done) begin
          state_d    = ST_RUN;
          fill_req_d = 1'b0;
          wait_d     = '0;
        end else if (wait_q == TIMEOUT_VAL) begin
          state_d    = ST_FAULT;
          fill_req_d = 1'b0;
          fault_d    = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_FAULT: begin
        fault_d = 1'b1;
      end
    endcase

    if (!rst_n) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_en     = 1'b0;
      id_ex_bubble = 1'b0;
    end

    stall_count_d = stall_count_q;
    if (!pc_we && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      wait_q        <= '0;
      fill_req_q    <= 1'b0;
      fill_sel_q    <= 1'b0;
      fault_q       <= 1'b0;
      stall_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      fill_req_q    <= fill_req_d;
      fill_sel_q    <= fill_sel_d;
      fault_q       <= fault_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fill_req    = fill_req_q;
  assign fill_sel    = fill_sel_q;
  assign fault       = fault_q;
  assign state       = state_q;
  assign stall_count = stall_count_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl : vector table, corner sequences and random run vs model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam int FT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        icache_hit = 1'b1, dmem_req = 1'b0, dcache_hit = 1'b1, fill_done = 1'b0;
  logic [2:0]  id_rs = '0, id_rt = '0, ex_rt = '0;
  logic        id_uses_rt = 1'b0, ex_mem_read = 1'b0, ex_branch_taken = 1'b0;
  logic        pc_we, if_id_we, if_id_flush, id_ex_en, id_ex_bubble;
  logic        fill_req, fill_sel, fault;
  logic [1:0]  state;
  logic [15:0] stall_count;

  pipeline_hazard_ctrl #(.FILL_TIMEOUT(FT), .WAIT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .icache_hit(icache_hit), .dmem_req(dmem_req),
    .dcache_hit(dcache_hit), .fill_done(fill_done), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .ex_branch_taken(ex_branch_taken), .pc_we(pc_we), .if_id_we(if_id_we),
    .if_id_flush(if_id_flush), .id_ex_en(id_ex_en), .id_ex_bubble(id_ex_bubble),
    .fill_req(fill_req), .fill_sel(fill_sel), .fault(fault), .state(state),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: mode 0 run, 1 ifill, 2 dfill, 3 fault
  int m_mode = 0, m_wait = 0, m_stall = 0;
  bit m_req = 0, m_sel = 0, m_fault = 0;

  // {pc_we, if_id_we, if_id_flush, id_ex_en, id_ex_bubble}
  function automatic logic [4:0] model_ctl();
    bit dm, im, hz;
    dm = dmem_req && !dcache_hit;
    im = !icache_hit;
    hz = ex_mem_read && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    if (!rst_n || m_mode != 0 || dm || im) return 5'b00000;
    if (ex_branch_taken) return 5'b11111;
    if (hz) return 5'b00011;
    return 5'b11010;
  endfunction

  task automatic model_edge(input logic [4:0] ctl);
    if (!rst_n) begin
      m_mode = 0; m_wait = 0; m_stall = 0; m_req = 0; m_sel = 0; m_fault = 0;
    end else begin
      if (!ctl[4] && m_stall < 65535) m_stall++;
      if (m_mode == 0) begin
        if (dmem_req && !dcache_hit) begin m_mode = 2; m_req = 1; m_sel = 1; end
        else if (!icache_hit) begin m_mode = 1; m_req = 1; m_sel = 0; end
      end else if (m_mode == 1 || m_mode == 2) begin
        if (fill_done) begin m_mode = 0; m_req = 0; m_wait = 0; end
        else if (m_wait == FT) begin m_mode = 3; m_req = 0; m_fault = 1; end
        else m_wait++;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic settle(input bit do_chk);
    logic [25:0] act, exp;
    #1;
    if (do_chk) begin
      act = {pc_we, if_id_we, if_id_flush, id_ex_en, id_ex_bubble,
             fill_req, fill_sel, fault, state, stall_count};
      exp = {model_ctl(), m_req, m_sel, m_fault, 2'(m_mode), 16'(m_stall)};
      chk("cycle", 32'(act), 32'(exp));
    end
  endtask

  task automatic advance();
    logic [4:0] ctl;
    ctl = model_ctl();
    @(posedge clk);
    model_edge(ctl);
    #1;
  endtask

  task automatic step(input bit do_chk);
    settle(do_chk);
    advance();
  endtask

  task automatic idle_inputs();
    icache_hit = 1; dmem_req = 0; dcache_hit = 1; fill_done = 0;
    id_rs = 0; id_rt = 0; ex_rt = 0; id_uses_rt = 0; ex_mem_read = 0; ex_branch_taken = 0;
  endtask

  task automatic do_reset();
    rst_n = 0; step(1); rst_n = 1;
  endtask

  typedef struct {
    logic dreq, dhit, mr, urt, br;
    logic [2:0] ert, rs, rt;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{dreq:0, dhit:1, mr:1, urt:0, br:0, ert:3, rs:3, rt:0, exp:5'b00011};
    vecs[1] = '{dreq:0, dhit:1, mr:1, urt:0, br:0, ert:3, rs:1, rt:3, exp:5'b11010};
    vecs[2] = '{dreq:0, dhit:1, mr:1, urt:1, br:0, ert:3, rs:1, rt:3, exp:5'b00011};
    vecs[3] = '{dreq:0, dhit:1, mr:0, urt:1, br:0, ert:3, rs:3, rt:3, exp:5'b11010};
    vecs[4] = '{dreq:0, dhit:1, mr:1, urt:0, br:1, ert:3, rs:3, rt:0, exp:5'b11111};
    vecs[5] = '{dreq:0, dhit:1, mr:1, urt:1, br:0, ert:5, rs:5, rt:5, exp:5'b00011};
    vecs[6] = '{dreq:0, dhit:1, mr:0, urt:0, br:0, ert:0, rs:0, rt:0, exp:5'b11010};
    vecs[7] = '{dreq:0, dhit:1, mr:1, urt:0, br:0, ert:0, rs:0, rt:7, exp:5'b00011};
    vecs[8] = '{dreq:1, dhit:1, mr:0, urt:0, br:0, ert:2, rs:2, rt:2, exp:5'b11010};

    idle_inputs();
    @(posedge clk); #1;

    // reset state
    rst_n = 0;
    settle(0);
    chk("reset_ctl", 32'({pc_we, if_id_we, if_id_flush, id_ex_en, id_ex_bubble}), 32'd0);
    advance();
    settle(0);
    chk("reset_regs", 32'({fill_req, fill_sel, fault, state, stall_count}), 32'd0);
    rst_n = 1;
    advance();
    step(1);

    // hazard vector table
    do_reset();
    for (int i = 0; i < 9; i++) begin
      dmem_req = vecs[i].dreq; dcache_hit = vecs[i].dhit; ex_mem_read = vecs[i].mr;
      id_uses_rt = vecs[i].urt; ex_branch_taken = vecs[i].br;
      ex_rt = vecs[i].ert; id_rs = vecs[i].rs; id_rt = vecs[i].rt;
      settle(1);
      chk($sformatf("vec%0d", i),
          32'({pc_we, if_id_we, if_id_flush, id_ex_en, id_ex_bubble}), 32'(vecs[i].exp));
      advance();
      if (i == 0) chk("lu_stall_count", 32'(stall_count), 32'd1);
    end
    idle_inputs();

    // D-miss with fill_done on the same cycle the watchdog would expire
    do_reset();
    dmem_req = 1; dcache_hit = 0;
    step(1);
    chk("dmiss_enter", 32'({state, fill_req, fill_sel}), 32'({2'd2, 1'b1, 1'b1}));
    for (int i = 0; i < 3; i++) step(1);
    fill_done = 1;
    step(1);
    fill_done = 0; dcache_hit = 1;
    chk("dmiss_exit", 32'({state, fill_req}), 32'({2'd0, 1'b0}));
    chk("dmiss_stalls", 32'(stall_count), 32'd5);
    step(1);

    // dmiss + imiss + branch together
    idle_inputs();
    dmem_req = 1; dcache_hit = 0; icache_hit = 0; ex_branch_taken = 1;
    step(1);
    chk("combo_dfill", 32'({state, fill_sel}), 32'({2'd2, 1'b1}));
    dmem_req = 0; dcache_hit = 1;
    step(1);
    fill_done = 1;
    step(1);
    fill_done = 0; icache_hit = 1;
    settle(1);
    chk("combo_flush", 32'({if_id_flush, id_ex_bubble}), 32'({1'b1, 1'b1}));
    advance();
    ex_branch_taken = 0; icache_hit = 0;
    step(1);
    chk("combo_ifill", 32'({state, fill_req, fill_sel}), 32'({2'd1, 1'b1, 1'b0}));
    fill_done = 1;
    step(1);
    idle_inputs();
    step(1);

    // reset in the second DFILL cycle, then a stray fill_done in RUN
    dmem_req = 1; dcache_hit = 0;
    step(1);
    step(1);
    rst_n = 0;
    step(1);
    chk("rst_midfill", 32'({state, fill_req}), 32'({2'd0, 1'b0}));
    rst_n = 1; idle_inputs(); fill_done = 1;
    step(1);
    fill_done = 0;
    chk("late_fill_done", 32'({state, fill_req}), 32'({2'd0, 1'b0}));
    step(1);

    // randomized run against the model
    for (int i = 0; i < 400; i++) begin
      icache_hit = ($urandom % 6) != 0;
      dmem_req = $urandom % 2;
      dcache_hit = ($urandom % 4) != 0;
      fill_done = ($urandom % 4) == 0;
      id_rs = 3'($urandom); id_rt = 3'($urandom); ex_rt = 3'($urandom);
      id_uses_rt = $urandom % 2; ex_mem_read = $urandom % 2;
      ex_branch_taken = ($urandom % 5) == 0;
      rst_n = (($urandom % 50) != 0) && !(m_mode == 3 && ($urandom % 3) == 0);
      step(1);
    end
    rst_n = 1;
    idle_inputs();

    // watchdog and stall_count saturation
    do_reset();
    icache_hit = 0;
    step(1);
    for (int i = 0; i < FT; i++) step(1);
    chk("wd_not_yet", 32'({state, fault}), 32'({2'd1, 1'b0}));
    step(1);
    settle(1);
    chk("wd_fault", 32'({state, fault, fill_req}), 32'({2'd3, 1'b1, 1'b0}));
    chk("wd_freeze", 32'({pc_we, if_id_we, if_id_flush, id_ex_en, id_ex_bubble}), 32'd0);
    advance();
    icache_hit = 1;
    for (int i = 0; i < 65540; i++) advance();
    step(1);
    chk("stall_sat", 32'(stall_count), 32'hFFFF);
    step(1);
    chk("stall_hold", 32'({stall_count, state}), 32'({16'hFFFF, 2'd3}));
    rst_n = 0;
    step(1);
    rst_n = 1;
    settle(1);
    chk("post_fault_reset", 32'({fill_req, fill_sel, fault, state, stall_count}), 32'd0);
    advance();
    step(1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
